xor_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one N-bit bitwise-XOR datapath among R requesters. Each requester presents operand pairs over a valid/ready handshake. The block grants at most one requester per cycle and computes `a ^ b` into a single registered result stage. Results leave on one valid/ready output tagged with the requester id. It sits between the per-channel operand producers and the shared XOR resource in the datapath.

---
 rtl/xor_share_arbiter_pkg.sv | 19 +
 rtl/rr_pick.sv | 43 ++++
 rtl/xor_share_arbiter.sv | 98 +++++++++
 tb/tb_xor_share_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/xor_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xor_share_arbiter_pkg
// Description : Shared types and defaults for the shared-XOR arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package xor_share_arbiter_pkg;

  localparam int DEF_N   = 32;
  localparam int DEF_R   = 4;
  localparam int DEF_IDW = 2;

  typedef enum logic [0:0] {
    XS_EMPTY = 1'b0,
    XS_FULL  = 1'b1
  } xs_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker over a doubled request vector.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [R-1:0]   grant,
  output logic [IDW-1:0] idx
);

  logic [2*R-1:0] w_dbl;
  logic [2*R-1:0] w_cand;
  logic [2*R-1:0] w_first;

  assign w_dbl = {req, req};

  // Only the R-wide window starting at ptr is eligible; the first hit wins.
  generate
    for (genvar j = 0; j < 2*R; j++) begin : g_scan
      localparam logic [2*R-1:0] c_below = (2*R)'((64'd1 << j) - 64'd1);
      assign w_cand[j]  = w_dbl[j] && (j >= int'(ptr)) && (j < int'(ptr) + R);
      assign w_first[j] = w_cand[j] && ((w_cand & c_below) == '0);
    end
    for (genvar i = 0; i < R; i++) begin : g_fold
      assign grant[i] = w_first[i] | w_first[i+R];
    end
  endgenerate

  always_comb begin
    idx = '0;
    for (int i = 0; i < R; i++) begin
      if (grant[i]) idx = idx | IDW'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/xor_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xor_share_arbiter
// Description : Round-robin sharing of one registered N-bit XOR among R requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_share_arbiter
  import xor_share_arbiter_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int R   = DEF_R,
  parameter int IDW = DEF_IDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N-1:0]   res_data,
  output logic [IDW-1:0] res_id,
  output logic           busy
);

  xs_state_e      r_state;
  xs_state_e      w_state_nxt;
  logic [N-1:0]   r_data;
  logic [N-1:0]   w_data_nxt;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] w_id_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_nxt;
  logic [R-1:0]   w_onehot;
  logic [IDW-1:0] w_idx;
  logic           w_free;
  logic           w_fire;
  logic [N-1:0]   w_xor;

  rr_pick #(
    .R   (R),
    .IDW (IDW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_onehot),
    .idx   (w_idx)
  );

  // A full slot being drained this cycle can be refilled on the same edge.
  assign w_free    = (r_state == XS_EMPTY) || res_ready;
  assign req_ready = (w_free && !rst) ? w_onehot : '0;
  assign w_fire    = |req_ready;

  always_comb begin
    w_xor = '0;
    for (int i = 0; i < R; i++) begin
      if (w_onehot[i]) w_xor = req_a[i*N +: N] ^ req_b[i*N +: N];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_id_nxt    = r_id;
    w_ptr_nxt   = r_ptr;
    if (w_fire) begin
      w_state_nxt = XS_FULL;
      w_data_nxt  = w_xor;
      w_id_nxt    = w_idx;
      w_ptr_nxt   = (w_idx == IDW'(R-1)) ? '0 : w_idx + IDW'(1);
    end else if ((r_state == XS_FULL) && res_ready) begin
      w_state_nxt = XS_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= XS_EMPTY;
      r_data  <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_id    <= w_id_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign res_valid = (r_state == XS_FULL);
  assign res_data  = r_data;
  assign res_id    = r_id;
  assign busy      = res_valid | (|req_valid);

endmodule
`default_nettype wire

// File: tb/tb_xor_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_share_arbiter
// Description : Directed plus randomized self-checking bench for xor_share_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_share_arbiter;

  localparam int N   = 32;
  localparam int R   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic           res_valid;
  logic           res_ready;
  logic [N-1:0]   res_data;
  logic [IDW-1:0] res_id;
  logic           busy;

  xor_share_arbiter #(.N(N), .R(R), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Requester side: pending operand pairs, auto re-armed if in rearm mask.
  logic [N-1:0] op_a [R];
  logic [N-1:0] op_b [R];
  bit           pend [R];
  bit [R-1:0]   rearm;

  // Reference model: contents of the result slot and the round-robin start.
  bit           m_valid;
  logic [N-1:0] m_data;
  int           m_id;
  int           m_ptr;

  // Last observed DUT values (mid-cycle samples).
  logic [R-1:0]   last_ready;
  logic           last_valid;
  logic [N-1:0]   last_data;
  logic [IDW-1:0] last_id;
  int             obs_ids[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    if (rst) return -1;
    if (m_valid && !res_ready) return -1;
    for (int k = 0; k < R; k++) begin
      if (pend[(m_ptr + k) % R]) return (m_ptr + k) % R;
    end
    return -1;
  endfunction

  task automatic arm(input int i);
    pend[i] = 1'b1;
    op_a[i] = $urandom;
    op_b[i] = $urandom;
  endtask

  task automatic step(input bit chk_en);
    int g;
    logic [R-1:0] exp_ready;
    bit any_pend;
    for (int i = 0; i < R; i++) begin
      req_valid[i]       = pend[i];
      req_a[i*N +: N]    = op_a[i];
      req_b[i*N +: N]    = op_b[i];
    end
    @(negedge clk);
    g = model_pick();
    exp_ready = (g >= 0) ? R'(1 << g) : '0;
    any_pend = 1'b0;
    for (int i = 0; i < R; i++) any_pend |= pend[i];
    last_ready = req_ready;
    last_valid = res_valid;
    last_data  = res_data;
    last_id    = res_id;
    if (chk_en) begin
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("res_valid", 64'(res_valid), 64'(m_valid));
      if (m_valid || rst === 1'b0) begin
        chk("res_data", 64'(res_data), 64'(m_data));
        chk("res_id", 64'(res_id), 64'(m_id));
      end
      chk("busy", 64'(busy), 64'(m_valid | any_pend));
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = 0;
      m_ptr   = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = op_a[g] ^ op_b[g];
      m_id    = g;
      m_ptr   = (g + 1) % R;
      pend[g] = 1'b0;
      if (rearm[g]) arm(g);
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < R; i++) pend[i] = 1'b0;
    rearm = '0;
  endtask

  initial begin
    int exp_seq[6];
    int skip_seq[4];
    exp_seq  = '{0, 1, 2, 3, 0, 1};
    skip_seq = '{1, 3, 1, 3};
    m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
    rearm = '0;
    res_ready = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < R; i++) arm(i);

    // Reset with all requesters valid
    step(1'b0);
    step(1'b1);
    chk("reset_ready", 64'(last_ready), 64'h0);
    chk("reset_data", 64'(last_data), 64'h0);

    // Single request from requester 2
    rst = 1'b0;
    clear_reqs();
    pend[2] = 1'b1; op_a[2] = 32'hFFFF0000; op_b[2] = 32'h0F0F0F0F;
    step(1'b1);
    chk("single_ready", 64'(last_ready), 64'b0100);
    step(1'b1);
    chk("single_valid", 64'(last_valid), 64'h1);
    chk("single_data", 64'(last_data), 64'hF0F00F0F);
    chk("single_id", 64'(last_id), 64'h2);

    // Pointer back to 0, then full contention
    rst = 1'b1; step(1'b1); rst = 1'b0;
    for (int i = 0; i < R; i++) arm(i);
    rearm = '1;
    obs_ids.delete();
    for (int s = 0; s < 7; s++) begin
      step(1'b1);
      if (last_valid) obs_ids.push_back(int'(last_id));
    end
    chk("contention_len", 64'(obs_ids.size()), 64'd6);
    for (int i = 0; i < 6 && i < obs_ids.size(); i++)
      chk($sformatf("contention_id%0d", i), 64'(obs_ids[i]), 64'(exp_seq[i]));

    // Backpressure for 3 cycles, then drain and refill on one edge
    res_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step(1'b1);
      chk("stall_ready", 64'(last_ready), 64'h0);
    end
    res_ready = 1'b1;
    step(1'b1);
    chk("release_grant", 64'(last_ready != 0), 64'h1);
    step(1'b1);

    // Pointer skip with only requesters 1 and 3
    clear_reqs();
    rst = 1'b1; step(1'b1); rst = 1'b0;
    arm(1); arm(3);
    rearm = 4'b1010;
    obs_ids.delete();
    for (int s = 0; s < 4; s++) begin
      step(1'b1);
      obs_ids.push_back(last_ready == 4'b0010 ? 1 : last_ready == 4'b1000 ? 3 : -1);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("skip_grant%0d", i), 64'(obs_ids[i]), 64'(skip_seq[i]));

    // Reset while full and stalled
    clear_reqs();
    step(1'b1);
    arm(3);
    step(1'b1);
    res_ready = 1'b0;
    arm(1); arm(2);
    step(1'b1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    step(1'b1);
    chk("midreset_valid", 64'(last_valid), 64'h0);
    chk("midreset_grant", 64'(last_ready), 64'b0010);
    res_ready = 1'b1;
    step(1'b1);

    // Randomized traffic against the model
    clear_reqs();
    for (int s = 0; s < 400; s++) begin
      rst       = ($urandom_range(0, 49) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < R; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) arm(i);
      step(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
